// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronised and deglitched PS2_CLK, 11-bit frame
// checking with an inter-edge timeout, E0/F0 prefix folding, and a DEPTH-entry
// event FIFO drained through a val/rdy handshake.
module ps2_keyboard_rx #(
  parameter int unsigned FILTER_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned DEPTH          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic       evt_val,
  input  logic       evt_rdy,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

  state_t        state_q, state_d;
  logic          ps2c_meta_q, ps2c_meta_d, ps2c_sync_q, ps2c_sync_d;
  logic          ps2d_meta_q, ps2d_meta_d, ps2d_sync_q, ps2d_sync_d;
  logic          clk_filt_q, clk_filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic [9:0]    mem_q [DEPTH], mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic fall, tmo, frame_end, byte_good, push, pop, full, push_ok;

  // All state registers; synchronous active-high reset, PS/2 lines idle high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ps2c_meta_q <= 1'b1;
      ps2c_sync_q <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_sync_q <= 1'b1;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ps2c_meta_q <= ps2c_meta_d;
      ps2c_sync_q <= ps2c_sync_d;
      ps2d_meta_q <= ps2d_meta_d;
      ps2d_sync_q <= ps2d_sync_d;
      clk_filt_q  <= clk_filt_d;
      filt_cnt_q  <= filt_cnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Two-flop synchronisers and the PS2_CLK stability filter with fall strobe
  always_comb begin
    ps2c_meta_d = PS2_CLK;
    ps2c_sync_d = ps2c_meta_q;
    ps2d_meta_d = PS2_DATA;
    ps2d_sync_d = ps2d_meta_q;
    clk_filt_d  = clk_filt_q;
    filt_cnt_d  = '0;
    if (ps2c_sync_q != clk_filt_q) begin
      if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) clk_filt_d = ps2c_sync_q;
      else                                      filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fall = clk_filt_q & ~clk_filt_d;
  end

  // Frame datapath: shift register, bit counter, parity latch, inter-edge timeout
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tmo       = (state_q != S_IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    to_cnt_d  = (state_q == S_IDLE || fall || tmo) ? '0 : to_cnt_q + 1'b1;
    if (fall) begin
      case (state_q)
        S_IDLE: bit_cnt_d = '0;
        S_DATA: begin
          shift_d   = {ps2d_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        S_PAR:   par_d = ps2d_sync_q;
        default: ;
      endcase
    end
  end

  // Next-state logic; timeout takes priority over everything but a fall
  always_comb begin
    state_d = state_q;
    if (tmo) begin
      state_d = S_IDLE;
    end else if (fall) begin
      case (state_q)
        S_IDLE:  if (!ps2d_sync_q) state_d = S_DATA;
        S_DATA:  if (bit_cnt_q == 3'd7) state_d = S_PAR;
        S_PAR:   state_d = S_STOP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: frame verdict, error pulse and event push request
  always_comb begin
    frame_end = fall && (state_q == S_STOP);
    byte_good = frame_end && ps2d_sync_q && (^{shift_q, par_q});
    frame_err = (frame_end && !byte_good) || tmo;
    push      = byte_good && (shift_q != 8'hE0) && (shift_q != 8'hF0);
  end

  // Prefix flags: set by E0/F0, consumed by the next pushed event, cleared on any error
  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    if (frame_err) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (byte_good) begin
      if (shift_q == 8'hE0)      ext_pend_d = 1'b1;
      else if (shift_q == 8'hF0) brk_pend_d = 1'b1;
      else begin
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  // Event FIFO; a pop frees the slot so a push into a full FIFO still succeeds
  always_comb begin
    evt_val  = (count_q != '0);
    pop      = evt_val && evt_rdy;
    full     = (count_q == CW'(DEPTH));
    push_ok  = push && (!full || pop);
    overflow = push && full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {brk_pend_q, ext_pend_q, shift_q};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
    {evt_brk, evt_ext, evt_code} = evt_val ? mem_q[rd_ptr_q] : '0;
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: good frames, prefixes, bad frames,
// timeout, clock glitch and FIFO overflow/drain.
module tb_ps2_keyboard_rx;

  localparam int unsigned TMO  = 200;
  localparam int unsigned HALF = 20;
  localparam int unsigned DEP  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic [7:0] evt_code;
  logic       evt_ext, evt_brk, evt_val, frame_err, overflow;
  logic       evt_rdy = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_err    = 0;
  int unsigned n_ovf    = 0;
  logic [9:0]  evq [$];

  ps2_keyboard_rx #(.FILTER_CYCLES(8), .TIMEOUT_CYCLES(TMO), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_brk(evt_brk),
    .evt_val(evt_val), .evt_rdy(evt_rdy),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Monitor: counts pulses and logs accepted events as {brk, ext, code}
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) n_err++;
      if (overflow) n_ovf++;
      if (evt_val && evt_rdy) evq.push_back({evt_brk, evt_ext, evt_code});
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Sends nbits of an 11-bit frame; glitch_bit inserts a 3-cycle low pulse in that bit's high phase
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_bit,
                            input int glitch_bit, input int nbits);
    logic [10:0] f;
    f = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA = f[i];
      if (i == glitch_bit) begin
        repeat (6) @(negedge clk);
        PS2_CLK = 1'b0;
        repeat (3) @(negedge clk);
        PS2_CLK = 1'b1;
        repeat (HALF - 9) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      PS2_CLK = 1'b0;
      repeat (HALF) @(negedge clk);
      PS2_CLK = 1'b1;
    end
    PS2_DATA = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, -1, 11);
  endtask

  initial begin
    int e0, q0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_val", {31'd0, evt_val}, 32'd0);
    check("rst_code", {24'd0, evt_code}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);

    // 1: single good frame 0x1C
    e0 = n_err; q0 = evq.size();
    good(8'h1C);
    check("t1_nev", evq.size() - q0, 32'd1);
    if (evq.size() > q0) check("t1_ev", {22'd0, evq[q0]}, {22'd0, 10'b00_0001_1100});
    check("t1_err", n_err - e0, 32'd0);

    // 2: prefixes folded into events
    q0 = evq.size();
    good(8'hF0); good(8'h1C);
    good(8'hE0); good(8'hF0); good(8'h75);
    check("t2_nev", evq.size() - q0, 32'd2);
    if (evq.size() >= q0 + 2) begin
      check("t2_ev0", {22'd0, evq[q0]},     {22'd0, 10'b10_0001_1100});
      check("t2_ev1", {22'd0, evq[q0 + 1]}, {22'd0, 10'b11_0111_0101});
    end

    // 3: bad parity, then bad stop
    e0 = n_err; q0 = evq.size();
    send_frame(8'h1C, 1'b1, 1'b1, -1, 11);
    check("t3_err_par", n_err - e0, 32'd1);
    send_frame(8'h1C, 1'b0, 1'b0, -1, 11);
    check("t3_err_stop", n_err - e0, 32'd2);
    check("t3_nev", evq.size() - q0, 32'd0);

    // 4: stall after 4 data bits, then recovery (prefix pending must be dropped too)
    e0 = n_err; q0 = evq.size();
    good(8'hF0);
    send_frame(8'h55, 1'b0, 1'b1, -1, 5);
    repeat (TMO + 50) @(negedge clk);
    check("t4_tmo_err", n_err - e0, 32'd1);
    good(8'h29);
    check("t4_nev", evq.size() - q0, 32'd1);
    if (evq.size() > q0) check("t4_ev", {22'd0, evq[q0]}, {22'd0, 10'b00_0010_1001});

    // 5: short clock glitch mid-frame is filtered out
    e0 = n_err; q0 = evq.size();
    send_frame(8'h5A, 1'b0, 1'b1, 4, 11);
    check("t5_nev", evq.size() - q0, 32'd1);
    if (evq.size() > q0) check("t5_ev", {22'd0, evq[q0]}, {22'd0, 10'b00_0101_1010});
    check("t5_err", n_err - e0, 32'd0);

    // 6: fill past DEPTH with consumer stalled, then drain
    evt_rdy = 1'b0;
    q0 = evq.size();
    e0 = n_ovf;
    for (int i = 1; i <= DEP + 1; i++) good(8'(i));
    check("t6_ovf", n_ovf - e0, 32'd1);
    check("t6_val", {31'd0, evt_val}, 32'd1);
    check("t6_head", {22'd0, evt_brk, evt_ext, evt_code}, 32'h01);
    repeat (5) @(negedge clk);
    check("t6_hold", {24'd0, evt_code}, 32'h01);
    evt_rdy = 1'b1;
    repeat (DEP + 4) @(negedge clk);
    check("t6_nev", evq.size() - q0, DEP);
    for (int i = 0; i < DEP; i++)
      if (evq.size() > q0 + i) check("t6_order", {22'd0, evq[q0 + i]}, 32'(i + 1));
    check("t6_empty", {31'd0, evt_val}, 32'd0);
    check("t6_code0", {24'd0, evt_code}, 32'd0);

    // mid-frame reset returns to idle; a following frame still decodes
    q0 = evq.size();
    send_frame(8'h33, 1'b0, 1'b1, -1, 4);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (HALF) @(negedge clk);
    good(8'h16);
    check("rst_mid_nev", evq.size() - q0, 32'd1);
    if (evq.size() > q0) check("rst_mid_ev", {22'd0, evq[q0]}, 32'h16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
